shift_reverse: RTL and testbench

Block-reversal buffer: accepts a stream of samples and emits each block of up to DEPTH samples in reversed order, newest first. It is the read-back counterpart of the shift-tap delay line in the Memory/SRAM/Shift library. Ping-pong SRAM banks allow one block to be written while the previous one is read out, so full-rate streams pass with no gaps. Used ahead of reversed-order filter structures and for time-reversal of framed data.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/sdp_ram.sv | 43 ++++
 rtl/shift_reverse.sv | 159 +++++++++++++++
 tb/tb_shift_reverse.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// shift_pkg : shared types and widths for the block-reversal buffer
// Rev 1.0
// ============================================================================
package shift_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned AW        = 4;
  localparam int unsigned DEF_DEPTH = 1 << AW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  typedef logic bank_t;

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// sdp_ram : simple dual-port RAM, one write port, one registered read port
// Rev 1.0
// ============================================================================
module sdp_ram #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [WORDS];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the read register is reset; the array itself needs no clearing.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/shift_reverse.sv
`default_nettype none
// ============================================================================
// shift_reverse : ping-pong block-reversal buffer, emits each block newest first
// Rev 1.0
// ============================================================================
module shift_reverse
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ivalid,
  output logic             iready,
  input  logic [WIDTH-1:0] shiftin,
  input  logic             flush,
  output logic             ovalid,
  output logic             olast,
  output logic [WIDTH-1:0] shiftout
);

  localparam int unsigned     ADDR_W = $clog2(DEPTH);
  localparam int unsigned     CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  bank_t             r_wr_bank;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [1:0]        r_pending;
  logic [CNT_W-1:0]  r_len [2];

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  bank_t             r_rd_bank;
  bank_t             w_rd_bank_nxt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic              w_rd_done;
  logic              w_rd_en;
  logic              r_ovalid;
  logic              r_olast;

  logic              w_accept;
  logic              w_close;
  logic [CNT_W-1:0]  w_cnt_eff;
  bank_t             w_next_bank;
  logic              w_next_ready;
  logic [CNT_W-1:0]  w_next_len;

  assign iready    = ~r_pending[r_wr_bank];
  assign w_accept  = ivalid & iready;
  assign w_cnt_eff = r_wr_cnt + (w_accept ? C_ONE : '0);
  assign w_close   = iready & ((w_cnt_eff == C_FULL) | (flush & (w_cnt_eff != '0)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else if (w_close) begin
      r_wr_bank <= ~r_wr_bank;
      r_wr_cnt  <= '0;
    end else if (w_accept) begin
      r_wr_cnt  <= w_cnt_eff;
    end
  end

  // A bank being read is always pending, so the writer never closes it on the
  // same edge the reader releases it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pending <= '0;
      r_len[0]  <= C_FULL;
      r_len[1]  <= C_FULL;
    end else begin
      if (w_rd_done) begin
        r_pending[r_rd_bank] <= 1'b0;
      end
      if (w_close) begin
        r_pending[r_wr_bank] <= 1'b1;
        r_len[r_wr_bank]     <= w_cnt_eff;
      end
    end
  end

  // Candidate bank to read next sees a block closing on this very edge too.
  always_comb begin
    w_next_bank  = (r_state == READ) ? ~r_rd_bank : r_rd_bank;
    w_next_ready = r_pending[w_next_bank] | (w_close & (r_wr_bank == w_next_bank));
    w_next_len   = r_pending[w_next_bank] ? r_len[w_next_bank] : w_cnt_eff;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_next_ready) begin
          w_state_nxt   = READ;
          w_rd_addr_nxt = ADDR_W'(w_next_len - C_ONE);
        end
      end
      READ: begin
        w_rd_addr_nxt = r_rd_addr - ADDR_W'(1);
        if (r_rd_addr == '0) begin
          w_rd_done     = 1'b1;
          w_rd_bank_nxt = ~r_rd_bank;
          if (w_next_ready) begin
            w_rd_addr_nxt = ADDR_W'(w_next_len - C_ONE);
          end else begin
            w_state_nxt   = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_rd_en = (r_state == READ);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rd_bank <= 1'b0;
      r_rd_addr <= '0;
      r_ovalid  <= 1'b0;
      r_olast   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_ovalid  <= w_rd_en;
      r_olast   <= w_rd_done;
    end
  end

  sdp_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_accept),
    .i_waddr ({r_wr_bank, r_wr_cnt[ADDR_W-1:0]}),
    .i_wdata (shiftin),
    .i_re    (w_rd_en),
    .i_raddr ({r_rd_bank, r_rd_addr}),
    .o_rdata (shiftout)
  );

  assign ovalid = r_ovalid;
  assign olast  = r_olast;

endmodule
`default_nettype wire

// File: tb/tb_shift_reverse.sv
`default_nettype none
// ============================================================================
// tb_shift_reverse : directed self-checking bench for shift_reverse
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_shift_reverse;

  localparam int W = 32;
  localparam int D = 16;

  logic         clock   = 1'b0;
  logic         reset   = 1'b0;
  logic         ivalid  = 1'b0;
  logic         flush   = 1'b0;
  logic [W-1:0] shiftin = '0;
  logic         iready;
  logic         ovalid;
  logic         olast;
  logic [W-1:0] shiftout;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] cap_q [$];

  shift_reverse #(.WIDTH(W), .DEPTH(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .ivalid   (ivalid),
    .iready   (iready),
    .shiftin  (shiftin),
    .flush    (flush),
    .ovalid   (ovalid),
    .olast    (olast),
    .shiftout (shiftout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (ovalid) cap_q.push_back({olast, shiftout});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ivalid = 1'b0; flush = 1'b0;
    repeat (2) tick();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
    n_cmp++; if (olast !== 1'b0) begin n_err++; $display("FAIL reset_olast: got %b expected 0", olast); end
    n_cmp++; if (shiftout !== '0) begin n_err++; $display("FAIL reset_shiftout: got %h expected 0", shiftout); end
    n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL reset_iready: got %b expected 1", iready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_block();
    logic [W+1:0] exp;
    for (int i = 0; i < D; i++) begin
      ivalid = 1'b1; shiftin = W'(i);
      tick();
      n_cmp++; if (ovalid !== 1'b0 || iready !== 1'b1) begin n_err++;
        $display("FAIL single_fill[%0d]: got ovalid=%b iready=%b expected ovalid=0 iready=1", i, ovalid, iready); end
    end
    ivalid = 1'b0;
    for (int k = 0; k < D; k++) begin
      tick();
      exp = {1'b1, (k == D-1), W'(D-1-k)};
      n_cmp++; if ({ovalid, olast, shiftout} !== exp) begin n_err++;
        $display("FAIL single_out[%0d]: got %h expected %h", k, {ovalid, olast, shiftout}, exp); end
    end
    tick();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL single_end: got ovalid=%b expected 0", ovalid); end
  endtask

  task automatic test_continuous();
    logic [W+1:0] exp;
    int j;
    for (int k = 0; k <= 80; k++) begin
      ivalid  = (k < 64);
      shiftin = W'(k);
      tick();
      if (k < 64) begin
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL cont_iready[%0d]: got %b expected 1", k, iready); end
      end
      if (k >= 16 && k < 80) begin
        j   = k - 16;
        exp = {1'b1, ((j % 16) == 15), W'((j / 16) * 16 + 15 - (j % 16))};
        n_cmp++; if ({ovalid, olast, shiftout} !== exp) begin n_err++;
          $display("FAIL cont_out[%0d]: got %h expected %h", j, {ovalid, olast, shiftout}, exp); end
      end else begin
        n_cmp++; if ({ovalid, olast} !== 2'b00) begin n_err++;
          $display("FAIL cont_idle[%0d]: got ovalid/olast=%b expected 00", k, {ovalid, olast}); end
      end
    end
  endtask

  task automatic test_flush();
    logic [W+1:0] exp [3];
    exp[0] = {1'b1, 1'b0, W'(102)};
    exp[1] = {1'b1, 1'b0, W'(101)};
    exp[2] = {1'b1, 1'b1, W'(100)};
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1; shiftin = W'(100 + i);
      tick();
    end
    ivalid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL flush_close: got ovalid=%b expected 0", ovalid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if ({ovalid, olast, shiftout} !== exp[k]) begin n_err++;
        $display("FAIL flush_out[%0d]: got %h expected %h", k, {ovalid, olast, shiftout}, exp[k]); end
    end
    tick();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL flush_end: got ovalid=%b expected 0", ovalid); end
  endtask

  task automatic test_flush_edge();
    logic [W+1:0] exp;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (ovalid !== 1'b0 || iready !== 1'b1) begin n_err++;
        $display("FAIL empty_flush[%0d]: got ovalid=%b iready=%b expected 0 1", k, ovalid, iready); end
    end
    ivalid = 1'b1; shiftin = W'(7); flush = 1'b1;
    tick();
    ivalid = 1'b0; flush = 1'b0;
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL one_close: got ovalid=%b expected 0", ovalid); end
    tick();
    exp = {1'b1, 1'b1, W'(7)};
    n_cmp++; if ({ovalid, olast, shiftout} !== exp) begin n_err++;
      $display("FAIL one_out: got %h expected %h", {ovalid, olast, shiftout}, exp); end
    tick();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL one_end: got ovalid=%b expected 0", ovalid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals [$];
    logic         flsh [$];
    logic [W:0]   exp  [$];
    int stalls = 0;
    int guard;
    vals.push_back(W'(50)); flsh.push_back(1'b1);
    for (int i = 0; i < 16; i++) begin vals.push_back(W'(i)); flsh.push_back(1'b0); end
    for (int i = 60; i < 63; i++) begin vals.push_back(W'(i)); flsh.push_back(i == 62); end
    for (int i = 16; i < 32; i++) begin vals.push_back(W'(i)); flsh.push_back(1'b0); end
    exp.push_back({1'b1, W'(50)});
    for (int i = 15; i >= 0; i--) exp.push_back({(i == 0), W'(i)});
    for (int i = 62; i >= 60; i--) exp.push_back({(i == 60), W'(i)});
    for (int i = 31; i >= 16; i--) exp.push_back({(i == 16), W'(i)});
    cap_q.delete();
    for (int s = 0; s < vals.size(); s++) begin
      ivalid = 1'b1; shiftin = vals[s]; flush = flsh[s];
      guard = 0;
      while (!iready && guard < 200) begin
        stalls++; guard++;
        tick();
      end
      if (guard >= 200) begin
        n_cmp++; n_err++; $display("FAIL b2b_timeout: got iready=%b expected 1 within 200 cycles", iready);
      end
      tick();
    end
    ivalid = 1'b0; flush = 1'b0;
    guard = 0;
    while (cap_q.size() < exp.size() && guard < 100) begin guard++; tick(); end
    repeat (3) tick();
    n_cmp++; if (stalls == 0) begin n_err++; $display("FAIL b2b_stall: got %0d stall cycles expected >0", stalls); end
    n_cmp++; if (cap_q.size() != exp.size()) begin n_err++;
      $display("FAIL b2b_count: got %0d outputs expected %0d", cap_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++) begin
      n_cmp++; if (cap_q[i] !== exp[i]) begin n_err++;
        $display("FAIL b2b_out[%0d]: got %h expected %h", i, cap_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W+1:0] exp;
    int seen = 0;
    for (int i = 0; i < D; i++) begin
      ivalid = 1'b1; shiftin = W'(300 + i);
      tick();
    end
    ivalid = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL midrst_ovalid: got %b expected 0", ovalid); end
    n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL midrst_iready: got %b expected 1", iready); end
    n_cmp++; if (olast !== 1'b0 || shiftout !== '0) begin n_err++;
      $display("FAIL midrst_out: got olast=%b shiftout=%h expected 0 0", olast, shiftout); end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ovalid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst_stale: got %0d valid cycles expected 0", seen); end
    ivalid = 1'b1; shiftin = W'(400);
    tick();
    shiftin = W'(401); flush = 1'b1;
    tick();
    ivalid = 1'b0; flush = 1'b0;
    tick();
    exp = {1'b1, 1'b0, W'(401)};
    n_cmp++; if ({ovalid, olast, shiftout} !== exp) begin n_err++;
      $display("FAIL midrst_out0: got %h expected %h", {ovalid, olast, shiftout}, exp); end
    tick();
    exp = {1'b1, 1'b1, W'(400)};
    n_cmp++; if ({ovalid, olast, shiftout} !== exp) begin n_err++;
      $display("FAIL midrst_out1: got %h expected %h", {ovalid, olast, shiftout}, exp); end
    tick();
    n_cmp++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL midrst_end: got ovalid=%b expected 0", ovalid); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_continuous();
    test_flush();
    test_flush_edge();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
